// File: rtl/mem_map_responder.sv
// mem_map_responder: timer/compare/scratch registers on a shared tri-state bus; optional prescaler under MAP_PRESCALE_EN.
// Reads are combinational, writes commit on the strobe edge; no backpressure, every access completes in its own cycle.
module mem_map_responder (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_memAddr,
  input  logic        i_memWr,
  input  logic        i_memMapEn,
  input  logic        i_isPaused,
  inout  wire  [15:0] io_memData,
  output logic        o_intr
);

  localparam logic [13:0] OFF_CTRL    = 14'h0000;
  localparam logic [13:0] OFF_TCNT    = 14'h0001;
  localparam logic [13:0] OFF_TCMP    = 14'h0002;
  localparam logic [13:0] OFF_STAT    = 14'h0003;
  localparam logic [13:0] OFF_SCRATCH = 14'h0004;

  logic [2:0]  r_ctrl_lo;
  logic [15:0] r_tcnt;
  logic [15:0] r_tcmp;
  logic [15:0] r_scratch;
  logic [1:0]  r_stat;

  logic [13:0] w_off;
  logic [15:0] w_wdata;
  logic [15:0] w_rdata;
  logic        w_drive;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_tcnt;
  logic        w_wr_tcmp;
  logic        w_wr_stat;
  logic        w_wr_scratch;
  logic [3:0]  w_ps;
  logic        w_ps_hit;
  logic        w_run;
  logic        w_tick;
  logic        w_match;
  logic        w_load0;
  logic        w_ovf;
  logic [1:0]  w_stat_clr;
  logic        w_unused_addr;

  // Only the low 14 address bits select a register; the strobe already qualifies the mapped window.
  assign w_off         = i_memAddr[13:0];
  assign w_unused_addr = &{1'b0, i_memAddr[15:14]};

  assign w_wdata      = io_memData;
  assign w_drive      = i_memMapEn & ~i_memWr;
  assign w_wr         = i_memMapEn & i_memWr;
  assign w_wr_ctrl    = w_wr & (w_off == OFF_CTRL);
  assign w_wr_tcnt    = w_wr & (w_off == OFF_TCNT);
  assign w_wr_tcmp    = w_wr & (w_off == OFF_TCMP);
  assign w_wr_stat    = w_wr & (w_off == OFF_STAT);
  assign w_wr_scratch = w_wr & (w_off == OFF_SCRATCH);

  assign w_run = r_ctrl_lo[0] & ~i_isPaused;

`ifdef MAP_PRESCALE_EN
  logic [3:0] r_ctrl_ps;
  logic [3:0] r_presc;

  assign w_ps     = r_ctrl_ps;
  assign w_ps_hit = (r_presc == r_ctrl_ps);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ctrl_ps <= 4'd0;
      r_presc   <= 4'd0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl_ps <= w_wdata[7:4];
        r_presc   <= 4'd0;
      end else if (w_run) begin
        r_presc <= w_ps_hit ? 4'd0 : r_presc + 4'd1;
      end
    end
  end
`else
  assign w_ps     = 4'd0;
  assign w_ps_hit = 1'b1;
`endif

  // A bus write to TCNT discards the whole tick, including its status side effects.
  assign w_tick     = w_run & w_ps_hit & ~w_wr_tcnt;
  assign w_match    = w_tick & (r_tcnt == r_tcmp);
  assign w_load0    = w_match & r_ctrl_lo[1];
  assign w_ovf      = w_tick & ~w_load0 & (r_tcnt == 16'hFFFF);
  assign w_stat_clr = w_wr_stat ? w_wdata[1:0] : 2'b00;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ctrl_lo <= 3'd0;
      r_tcnt    <= 16'h0000;
      r_tcmp    <= 16'h0000;
      r_scratch <= 16'h0000;
      r_stat    <= 2'b00;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl_lo <= w_wdata[2:0];
      end
      if (w_wr_tcnt) begin
        r_tcnt <= w_wdata;
      end else if (w_load0) begin
        r_tcnt <= 16'h0000;
      end else if (w_tick) begin
        r_tcnt <= r_tcnt + 16'h0001;
      end
      if (w_wr_tcmp) begin
        r_tcmp <= w_wdata;
      end
      if (w_wr_scratch) begin
        r_scratch <= w_wdata;
      end
      // Hardware set wins over a same-cycle write-1-to-clear.
      r_stat <= (r_stat & ~w_stat_clr) | {w_ovf, w_match};
    end
  end

  always_comb begin
    w_rdata = 16'h0000;
    case (w_off)
      OFF_CTRL:    w_rdata = {8'h00, w_ps, 1'b0, r_ctrl_lo};
      OFF_TCNT:    w_rdata = r_tcnt;
      OFF_TCMP:    w_rdata = r_tcmp;
      OFF_STAT:    w_rdata = {14'h0000, r_stat};
      OFF_SCRATCH: w_rdata = r_scratch;
      default:     w_rdata = 16'h0000;
    endcase
  end

  assign io_memData = w_drive ? w_rdata : 16'hzzzz;
  assign o_intr     = r_stat[0] & r_ctrl_lo[2];

endmodule

// File: doc/mem_map_responder.md
MEM_MAP_RESPONDER -- requirements
Module: mem_map_responder

Interface
REQ-001 The block SHALL have ports: i_clk  input  1  sole clock, all state on rising edge.
REQ-002 The block SHALL have ports: i_rstn  input  1  asynchronous active-low reset.
REQ-003 The block SHALL have ports: i_memAddr  input  16  word address from memory bus.
REQ-004 The block SHALL have ports: i_memWr  input  1  1=write, 0=read.
REQ-005 The block SHALL have ports: i_memMapEn  input  1  mapped-space access strobe (0xC000-0xFFFF).
REQ-006 The block SHALL have ports: i_isPaused  input  1  MCU paused; freezes timer.
REQ-007 The block SHALL have ports: io_memData  inout  16  shared data net; driven only on mapped reads.
REQ-008 The block SHALL have ports: o_intr  output  1  timer interrupt request.

Function
REQ-009 The block SHALL decode i_memAddr[13:0]: 0x0000 CTRL, 0x0001 TCNT, 0x0002 TCMP, 0x0003 STAT, 0x0004 SCRATCH; all other offsets unmapped.
REQ-010 The block SHALL drive io_memData combinationally with the addressed register when i_memMapEn=1 and i_memWr=0, and SHALL hold it Hi-Z otherwise.
REQ-011 Unmapped reads SHALL return 0x0000; unmapped writes SHALL change no state.
REQ-012 Writes SHALL commit on the rising edge where i_memMapEn=1 and i_memWr=1, sampling io_memData; read-back of a written value is valid the following cycle.
REQ-013 CTRL bits SHALL be: [0] timer enable, [1] auto-clear on match, [2] interrupt enable, [7:4] prescale; [15:8] and [3] read 0, writes ignored.
REQ-014 A tick SHALL occur when CTRL[0]=1, i_isPaused=0 and the prescale counter equals CTRL[7:4]; the prescale counter then returns to 0, otherwise increments; it holds while disabled or paused.
REQ-015 On a tick TCNT SHALL increment modulo 2^16; 0xFFFF->0x0000 SHALL set STAT[1] (overflow).
REQ-016 On a tick where the pre-increment TCNT equals TCMP, STAT[0] (match) SHALL be set; if CTRL[1]=1 TCNT SHALL load 0x0000 instead of incrementing.
REQ-017 STAT SHALL be write-1-to-clear on bits [1:0]; bits [15:2] read 0.
REQ-018 If a hardware set and a W1C clear of the same STAT bit occur in one cycle, set SHALL win.
REQ-019 If a bus write to TCNT coincides with a tick, the written value SHALL win and the tick SHALL be discarded.
REQ-020 A write to CTRL SHALL reset the prescale counter to 0.
REQ-021 o_intr SHALL equal registered STAT[0] AND CTRL[2], with no added latency beyond the register.
REQ-022 TCMP and SCRATCH SHALL be plain 16-bit read/write registers.

Reset
REQ-023 On i_rstn=0 all registers, the prescale counter and o_intr SHALL go to 0 immediately, independent of i_clk.
REQ-024 io_memData drive SHALL remain governed only by REQ-010 during reset (reads return 0x0000).
REQ-025 Deassertion SHALL take effect on the first rising edge with i_rstn=1; no tick SHALL occur on that edge.

Configuration
REQ-026 With macro MAP_PRESCALE_EN defined, the prescaler SHALL behave per REQ-014.
REQ-027 Without MAP_PRESCALE_EN, CTRL[7:4] SHALL read 0 and ignore writes, no prescale counter SHALL exist, and a tick SHALL occur every cycle with CTRL[0]=1 and i_isPaused=0.

Verification
REQ-028 Write CTRL=0x0001, TCMP=0x0003; after 4 ticks -> STAT=0x0001, TCNT=0x0004, o_intr=0; then CTRL=0x0007 -> o_intr=1 next cycle.
REQ-029 TCNT=0xFFFF, enable, one tick -> TCNT=0x0000, STAT[1]=1; write STAT=0x0002 -> STAT=0x0000.
REQ-030 CTRL=0x0031 (prescale 3) with MAP_PRESCALE_EN -> TCNT increments every 4 cycles; without macro -> every cycle, CTRL reads 0x0001.
REQ-031 Same-cycle W1C of STAT[0] and match event -> STAT[0] stays 1; TCNT write 0x1234 coinciding with a tick -> TCNT=0x1234.
REQ-032 Read 0xC004 after writing 0xBEEF -> io_memData=0xBEEF; read 0xC00F -> 0x0000; i_memMapEn=0 -> io_memData Hi-Z; i_isPaused=1 -> TCNT frozen; i_rstn pulse mid-count -> all registers 0x0000.
